// File: rtl/sram_ctrl_16x4_if.sv
// Requester-side handshake bundle for sram_ctrl_16x4.
//   req   : transaction request (sampled by the controller only when idle)
//   wr    : 1 = write, 0 = read; latched with req
//   addr  : target address; latched with req
//   wdata : write data; latched with req
//   rdata : last read result; holds until the next read completes
//   ack   : one-cycle completion pulse
//   busy  : high while a transaction is in progress
// master = requester, slave = controller.
interface sram_ctrl_16x4_if;
    logic       req;
    logic       wr;
    logic [3:0] addr;
    logic [3:0] wdata;
    logic [3:0] rdata;
    logic       ack;
    logic       busy;

    modport master (
        output req, wr, addr, wdata,
        input  rdata, ack, busy
    );

    modport slave (
        input  req, wr, addr, wdata,
        output rdata, ack, busy
    );
endinterface

// File: rtl/sram_ctrl_16x4.sv
// Sequencer for a 16x4 asynchronous SRAM with a shared bidirectional data bus.
// A single-cycle req/ack transaction on the host interface is expanded into
// setup, strobe and turnaround phases so the bus is never contended.
//
// Ports:
//   clk    : system clock, rising edge active
//   rst_n  : asynchronous active-low reset
//   host   : requester handshake (slave modport of sram_ctrl_16x4_if)
//   n_cs   : memory chip select, active low
//   n_we   : memory write strobe, active low
//   n_oe   : memory output enable, active low
//   a      : memory address
//   d      : memory data bus, driven only during write phases
//
// State        | meaning
// -------------+-----------------------------------------------------------
// S_IDLE       | bus released, strobes high, waiting for req
// S_W_SETUP    | n_cs low, address and data presented, n_we still high
// S_W_PULSE    | n_we low for WR_PULSE cycles
// S_W_HOLD     | n_we high, address/data held, ack pulse
// S_R_SETUP    | n_cs low, address presented, bus released, n_oe high
// S_R_OE       | n_oe low for RD_WAIT cycles; bus sampled on exit
// S_R_TURN     | n_oe high, ack pulse, memory releases the bus
module sram_ctrl_16x4 #(
    parameter int WR_PULSE = 2,
    parameter int RD_WAIT  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    sram_ctrl_16x4_if.slave    host,
    output logic               n_cs,
    output logic               n_we,
    output logic               n_oe,
    output logic [3:0]         a,
    inout  wire  [3:0]         d
);

    if (WR_PULSE < 1 || WR_PULSE > 15) begin : g_bad_wr_pulse
        $error("sram_ctrl_16x4: WR_PULSE=%0d outside 1..15", WR_PULSE);
    end
    if (RD_WAIT < 1 || RD_WAIT > 15) begin : g_bad_rd_wait
        $error("sram_ctrl_16x4: RD_WAIT=%0d outside 1..15", RD_WAIT);
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_SETUP,
        S_W_PULSE,
        S_W_HOLD,
        S_R_SETUP,
        S_R_OE,
        S_R_TURN
    } state_t;

    localparam logic [3:0] WR_LOAD = 4'(WR_PULSE - 1);
    localparam logic [3:0] RD_LOAD = 4'(RD_WAIT - 1);

    state_t     state;
    logic [3:0] cnt;
    logic [3:0] d_out;
    logic       d_oe;
    logic [3:0] rdata_q;
    logic       ack_q;
    logic       busy_q;

    assign d          = d_oe ? d_out : 4'bz;
    assign host.rdata = rdata_q;
    assign host.ack   = ack_q;
    assign host.busy  = busy_q;

    // Every output is registered and set one edge ahead, i.e. the values
    // assigned in a branch are the ones seen during the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            d_out   <= 4'd0;
            d_oe    <= 1'b0;
            n_cs    <= 1'b1;
            n_we    <= 1'b1;
            n_oe    <= 1'b1;
            a       <= 4'd0;
            rdata_q <= 4'd0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (host.req) begin
                        busy_q <= 1'b1;
                        n_cs   <= 1'b0;
                        a      <= host.addr;
                        d_out  <= host.wdata;
                        if (host.wr) begin
                            d_oe  <= 1'b1;
                            state <= S_W_SETUP;
                        end else begin
                            state <= S_R_SETUP;
                        end
                    end
                end
                S_W_SETUP: begin
                    n_we  <= 1'b0;
                    cnt   <= WR_LOAD;
                    state <= S_W_PULSE;
                end
                S_W_PULSE: begin
                    if (cnt == 4'd0) begin
                        n_we  <= 1'b1;
                        ack_q <= 1'b1;
                        state <= S_W_HOLD;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_W_HOLD: begin
                    ack_q  <= 1'b0;
                    busy_q <= 1'b0;
                    n_cs   <= 1'b1;
                    d_oe   <= 1'b0;
                    state  <= S_IDLE;
                end
                S_R_SETUP: begin
                    n_oe  <= 1'b0;
                    cnt   <= RD_LOAD;
                    state <= S_R_OE;
                end
                S_R_OE: begin
                    if (cnt == 4'd0) begin
                        rdata_q <= d;
                        n_oe    <= 1'b1;
                        ack_q   <= 1'b1;
                        state   <= S_R_TURN;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_R_TURN: begin
                    ack_q  <= 1'b0;
                    busy_q <= 1'b0;
                    n_cs   <= 1'b1;
                    state  <= S_IDLE;
                end
                default: begin
                    ack_q  <= 1'b0;
                    busy_q <= 1'b0;
                    n_cs   <= 1'b1;
                    n_we   <= 1'b1;
                    n_oe   <= 1'b1;
                    d_oe   <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_ctrl_16x4.sv
// Directed bench for sram_ctrl_16x4 with a behavioural 16x4 RAM on the bus.
module tb_sram_ctrl_16x4;

    localparam int WR_PULSE = 2;
    localparam int RD_WAIT  = 2;

    logic       clk;
    logic       rst_n;
    logic       n_cs;
    logic       n_we;
    logic       n_oe;
    logic [3:0] a;
    wire  [3:0] d;

    sram_ctrl_16x4_if host ();

    sram_ctrl_16x4 #(.WR_PULSE(WR_PULSE), .RD_WAIT(RD_WAIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .host  (host),
        .n_cs  (n_cs),
        .n_we  (n_we),
        .n_oe  (n_oe),
        .a     (a),
        .d     (d)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // RAM model
    logic [3:0] mem [16];
    assign d = (!n_cs && !n_oe) ? mem[a] : 4'bz;
    always @(posedge n_we) begin
        if (!n_cs) mem[a] = d;
    end

    int n_vec  = 0;
    int n_mis  = 0;
    int ack_cnt = 0;
    int bus_err = 0;

    always @(negedge clk) begin
        if (host.ack) ack_cnt++;
        if (rst_n) begin
            if (dut.d_oe && !n_oe) bus_err++;
            if (!n_we && !dut.d_oe) bus_err++;
        end
    end

    typedef struct {
        bit         wr;
        logic [3:0] addr;
        logic [3:0] wdata;
        logic [3:0] exp;
        bit         junk;
    } vec_t;

    vec_t vecs [40];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        int   lat;
        int   nwe_lo;
        int   noe_lo;
        v      = vecs[i];
        lat    = -1;
        nwe_lo = 0;
        noe_lo = 0;
        @(negedge clk);
        host.req   = 1'b1;
        host.wr    = v.wr;
        host.addr  = v.addr;
        host.wdata = v.wdata;
        @(posedge clk);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c == 0) begin
                chk($sformatf("v%0d busy_rise", i), int'(host.busy), 1);
                if (v.junk) begin
                    host.wr    = 1'b1;
                    host.addr  = 4'd7;
                    host.wdata = 4'd9;
                end else begin
                    host.req = 1'b0;
                end
            end
            if (!n_we) nwe_lo++;
            if (!n_oe) noe_lo++;
            if (host.ack) begin
                lat      = c;
                host.req = 1'b0;
                break;
            end
        end
        host.req = 1'b0;
        chk($sformatf("v%0d ack_latency", i), lat, (v.wr ? WR_PULSE : RD_WAIT) + 1);
        chk($sformatf("v%0d nwe_low_cycles", i), nwe_lo, v.wr ? WR_PULSE : 0);
        chk($sformatf("v%0d noe_low_cycles", i), noe_lo, v.wr ? 0 : RD_WAIT);
        if (!v.wr) chk($sformatf("v%0d rdata", i), int'(host.rdata), int'(v.exp));
        @(negedge clk);
        chk($sformatf("v%0d idle_after", i),
            int'({host.busy, n_cs, host.ack, dut.d_oe}), 4);
    endtask

    initial begin
        int snap;
        for (int k = 0; k < 16; k++) mem[k] = 4'd0;

        vecs[0] = '{1'b1, 4'h5, 4'hF, 4'h0, 1'b0};
        vecs[1] = '{1'b0, 4'h5, 4'h0, 4'hF, 1'b0};
        vecs[2] = '{1'b1, 4'hA, 4'h1, 4'h0, 1'b0};
        vecs[3] = '{1'b1, 4'hA, 4'h2, 4'h0, 1'b0};
        vecs[4] = '{1'b0, 4'hA, 4'h0, 4'h2, 1'b0};
        for (int k = 0; k < 16; k++) begin
            vecs[5 + k]  = '{1'b1, 4'(k), 4'(k) ^ 4'h3, 4'h0, 1'b0};
            vecs[21 + k] = '{1'b0, 4'(k), 4'h0, 4'(k) ^ 4'h3, 1'b0};
        end
        vecs[37] = '{1'b1, 4'h2, 4'h6, 4'h0, 1'b1};
        vecs[38] = '{1'b0, 4'h7, 4'h0, 4'h4, 1'b0};
        vecs[39] = '{1'b0, 4'h2, 4'h0, 4'h6, 1'b0};

        host.req   = 1'b0;
        host.wr    = 1'b0;
        host.addr  = 4'd0;
        host.wdata = 4'd0;
        rst_n      = 1'b0;

        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("reset c%0d", c),
                int'({n_cs, n_we, n_oe, dut.d_oe, host.rdata, host.ack, host.busy}),
                int'({1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0}));
        end
        rst_n = 1'b1;

        run_vec(0);
        run_vec(1);

        snap = ack_cnt;
        for (int i = 2; i <= 4; i++) run_vec(i);
        chk("back_to_back ack_count", ack_cnt - snap, 3);

        for (int i = 5; i <= 36; i++) run_vec(i);

        snap = ack_cnt;
        run_vec(37);
        repeat (3) @(negedge clk);
        chk("req_while_busy ack_count", ack_cnt - snap, 1);
        run_vec(38);
        run_vec(39);

        // Reset in the middle of the write strobe.
        snap = ack_cnt;
        @(negedge clk);
        host.req   = 1'b1;
        host.wr    = 1'b1;
        host.addr  = 4'h4;
        host.wdata = 4'hC;
        @(negedge clk);
        host.req = 1'b0;
        @(negedge clk);
        chk("midreset nwe_low_before", int'(n_we), 0);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset strobes_released",
            int'({n_cs, n_we, n_oe, dut.d_oe, host.busy}), int'(5'b11100));
        repeat (2) @(negedge clk);
        chk("midreset no_ack", ack_cnt - snap, 0);
        rst_n = 1'b1;
        vecs[0] = '{1'b0, 4'h4, 4'h0, 4'h0, 1'b0};
        begin
            int lat;
            lat = -1;
            @(negedge clk);
            host.req  = 1'b1;
            host.wr   = 1'b0;
            host.addr = 4'h4;
            @(posedge clk);
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                host.req = 1'b0;
                if (host.ack) begin
                    lat = c;
                    break;
                end
            end
            chk("post_reset read ack_latency", lat, RD_WAIT + 1);
        end

        chk("bus_monitor errors", bus_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
